flashmem_controller: RTL
========================

Name: flashmem_controller

Overview:
- Wishbone slave sequencer that drives the flashmem wrapper's command interface (FM_ADDR/FM_WD/FM_REN/FM_WEN/FM_PROGRAM) and returns its FM_RD/FM_STATUS.
- Turns 16-bit bus register accesses into single flash read, write-to-page-buffer and program commands, and enforces the FM_BUSY handshake.
- Provides auto-incrementing addressing and a timeout watchdog.
- Sits between the monitor's Wishbone interconnect and the flashmem instance.

Parameters:
- TIMEOUT_W, 20, width of the busy-wait watchdog counter. Timeout is 2^TIMEOUT_W-1 cycles.
- AUTO_INC, 1, when 1 the flash word address increments after each completed DATA read or write.

Ports:
- wb_clk_i  in  1  system clock; also drives FM_CLK at top level.
- wb_rst_ni  in  1  synchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  bus strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  2  register select: 0=ADDR_HI, 1=ADDR_LO, 2=DATA, 3=CTRL/STAT.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- fm_addr  out  17  flash word address, to FM_ADDR.
- fm_wd  out  16  write data, to FM_WD.
- fm_ren  out  1  read command, to FM_REN.
- fm_wen  out  1  write command, to FM_WEN.
- fm_program  out  1  program command, to FM_PROGRAM.
- fm_pagestatus  out  1  constant 0.
- fm_rd  in  32  read data; only [15:0] is used.
- fm_busy  in  1  flash busy.
- fm_status  in  2  flash status of the last operation.

Behaviour:
- Reset (wb_rst_ni low at a clock edge):
  - State goes to IDLE.
  - fm_addr, fm_wd, wb_dat_o go to 0.
  - fm_ren, fm_wen, fm_program, wb_ack_o go to 0.
  - Sticky err, stat_q and timeout counter go to 0.
  - Reset mid-operation abandons the command immediately. Any in-flight bus cycle is not acked.
- Register map:
  - ADDR_HI: bit0 = fm_addr[16]; other bits read 0.
  - ADDR_LO: fm_addr[15:0].
  - DATA: read performs a flash read; write performs a flash write.
  - CTRL write: bit0=1 starts a program; bit1=1 clears err.
  - STAT read: bit0=controller busy (state != IDLE), bit1=err, bits[3:2]=stat_q, bits[15:4]=0.
- States: IDLE, CMD, WAIT_HI, WAIT_LO.
- IDLE:
  - Bus access (cyc&stb) to ADDR_HI, ADDR_LO or CTRL/STAT: acked the next cycle; registers update on that ack cycle.
  - DATA access or CTRL program start: command is latched. Goes to CMD once fm_busy=0; stays in IDLE while fm_busy=1.
- CMD:
  - Exactly one cycle with the matching fm_ren, fm_wen or fm_program high.
  - fm_wd holds wb_dat_i for writes.
  - fm_addr is stable from CMD through the end of WAIT_LO.
  - Next state is WAIT_HI.
- WAIT_HI: leaves on fm_busy=1 to WAIT_LO, or after 4 cycles without busy to WAIT_LO. This tolerates zero-latency completion.
- WAIT_LO:
  - On fm_busy=0: capture fm_status into stat_q. For reads, capture fm_rd[15:0] into wb_dat_o. Return to IDLE.
  - err is set if fm_status != 0.
- DATA access ack: wb_ack_o pulses one cycle when WAIT_LO exits. The bus stalls (no ack) for the full flash latency.
- Program ack: acked in the cycle after CMD, without waiting for completion. Software polls STAT bit0.
- Timeout:
  - Counter runs in WAIT_HI/WAIT_LO and clears on entering CMD.
  - At terminal count: err=1, stat_q=2'b11, return to IDLE, and ack any pending DATA access with wb_dat_o=16'hDEAD.
- Auto-increment (AUTO_INC=1): fm_addr += 1 after each completed DATA access, wrapping 17'h1FFFF to 0. Program does not increment.
- Bus accesses while state != IDLE:
  - STAT read: acked.
  - Any other access: stalled until IDLE.
- wb_ack_o is never high on two consecutive cycles. The bus must drop stb after ack.
- Simultaneous CTRL write with bit0=1 and bit1=1: err is cleared first; a fault in the new program sets err again.

Test Plan:
- Reset: hold wb_rst_ni=0 for 3 cycles -> all outputs 0, STAT reads 16'h0000.
- Address setup: write ADDR_HI=1, ADDR_LO=16'h0010 -> fm_addr=17'h10010.
- Read: DATA read with flash model (busy 5 cycles, fm_rd=32'h0000_BEEF) -> one fm_ren pulse at 17'h10010, ack with 16'hBEEF, fm_addr then 17'h10011.
- Write then program: DATA write 16'h1234 -> fm_wen pulse, fm_wd=16'h1234. CTRL=1 -> ack immediate, STAT bit0=1 until busy falls. fm_status=2'b01 -> STAT=16'h0006. CTRL=2 -> err cleared.
- Busy at entry: hold fm_busy=1 for 10 cycles, then issue a DATA read -> no fm_ren until fm_busy=0, then exactly one pulse.
- Timeout/wrap: TIMEOUT_W=4, fm_busy stuck at 1 -> ack at terminal count with 16'hDEAD and err=1. Read at fm_addr=17'h1FFFF -> fm_addr wraps to 0.

Source files
------------

// File: rtl/flashmem_controller_if.sv
// Bus bundle between the Wishbone interconnect, the flash sequencer and the
// flashmem wrapper command port.
interface flashmem_controller_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic [16:0] fm_addr;
    logic [15:0] fm_wd;
    logic        fm_ren;
    logic        fm_wen;
    logic        fm_program;
    logic        fm_pagestatus;
    logic [31:0] fm_rd;
    logic        fm_busy;
    logic [1:0]  fm_status;

    // Controller side: serves the Wishbone bus, drives the flash commands.
    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o,
        output fm_addr, fm_wd, fm_ren, fm_wen, fm_program, fm_pagestatus,
        input  fm_rd, fm_busy, fm_status
    );

    // Environment side: Wishbone master plus flashmem wrapper.
    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o,
        input  fm_addr, fm_wd, fm_ren, fm_wen, fm_program, fm_pagestatus,
        output fm_rd, fm_busy, fm_status
    );
endinterface

// File: rtl/flashmem_controller.sv
// Wishbone register front-end that sequences single flashmem read, write and
// program commands, honours FM_BUSY, auto-increments the word address and
// guards every flash wait with a watchdog.
module flashmem_controller #(
    parameter int TIMEOUT_W = 20,
    parameter int AUTO_INC  = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    flashmem_controller_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CMD     = 2'd1;
    localparam logic [1:0] S_WAIT_HI = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;

    localparam logic [1:0] R_ADDR_HI = 2'd0;
    localparam logic [1:0] R_ADDR_LO = 2'd1;
    localparam logic [1:0] R_DATA    = 2'd2;
    localparam logic [1:0] R_CTRL    = 2'd3;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_PROG   = 2'd2;

    localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

    logic [1:0]           state;
    logic [1:0]           op_q;
    logic [16:0]          addr_q;
    logic [15:0]          wd_q;
    logic [15:0]          dat_q;
    logic                 ren_q;
    logic                 wen_q;
    logic                 prog_q;
    logic                 ack_q;
    logic                 err_q;
    logic [1:0]           stat_q;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [1:0]           hi_cnt;

    logic req;
    logic is_data;
    logic is_prog;
    logic is_stat_rd;
    logic waiting;
    logic done;
    logic tmo;
    logic unused_rd_hi;

    // STAT register image: busy, sticky error and last flash status.
    function automatic logic [15:0] stat_word(input logic busy, input logic err,
                                              input logic [1:0] stat);
        return {12'h000, stat, err, busy};
    endfunction

    // A new request is ignored in the ack cycle so the bus has time to drop stb.
    assign req        = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    assign is_data    = (bus.wb_adr_i == R_DATA);
    assign is_prog    = (bus.wb_adr_i == R_CTRL) & bus.wb_we_i & bus.wb_dat_i[0];
    assign is_stat_rd = (bus.wb_adr_i == R_CTRL) & ~bus.wb_we_i;
    assign waiting    = (state == S_WAIT_HI) | (state == S_WAIT_LO);
    assign done       = (state == S_WAIT_LO) & ~bus.fm_busy;
    assign tmo        = waiting & ~done & (to_cnt == '1);

    assign unused_rd_hi = ^bus.fm_rd[31:16];

    assign bus.wb_dat_o      = dat_q;
    assign bus.wb_ack_o      = ack_q;
    assign bus.fm_addr       = addr_q;
    assign bus.fm_wd         = wd_q;
    assign bus.fm_ren        = ren_q;
    assign bus.fm_wen        = wen_q;
    assign bus.fm_program    = prog_q;
    assign bus.fm_pagestatus = 1'b0;

    // Command sequencer, register file, watchdog and bus acknowledge.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state  <= S_IDLE;
            op_q   <= OP_READ;
            addr_q <= '0;
            wd_q   <= '0;
            dat_q  <= '0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            prog_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            stat_q <= '0;
            to_cnt <= '0;
            hi_cnt <= '0;
        end else begin
            ack_q  <= 1'b0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            prog_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (is_data || is_prog) begin
                            // Flash commands wait here until the wrapper is free.
                            if (!bus.fm_busy) begin
                                state  <= S_CMD;
                                op_q   <= is_prog ? OP_PROG : (bus.wb_we_i ? OP_WRITE : OP_READ);
                                ren_q  <= is_data & ~bus.wb_we_i;
                                wen_q  <= is_data & bus.wb_we_i;
                                prog_q <= is_prog;
                                to_cnt <= '0;
                                hi_cnt <= '0;
                                if (is_data && bus.wb_we_i) begin
                                    wd_q <= bus.wb_dat_i;
                                end
                                // Clear-before-program: a fault in this program re-arms err.
                                if (is_prog && bus.wb_dat_i[1]) begin
                                    err_q <= 1'b0;
                                end
                            end
                        end else begin
                            ack_q <= 1'b1;
                            case (bus.wb_adr_i)
                                R_ADDR_HI: begin
                                    if (bus.wb_we_i) addr_q[16] <= bus.wb_dat_i[0];
                                    else             dat_q <= {15'h0000, addr_q[16]};
                                end
                                R_ADDR_LO: begin
                                    if (bus.wb_we_i) addr_q[15:0] <= bus.wb_dat_i;
                                    else             dat_q <= addr_q[15:0];
                                end
                                default: begin
                                    if (bus.wb_we_i) begin
                                        if (bus.wb_dat_i[1]) err_q <= 1'b0;
                                    end else begin
                                        dat_q <= stat_word(1'b0, err_q, stat_q);
                                    end
                                end
                            endcase
                        end
                    end
                end
                S_CMD: begin
                    state <= S_WAIT_HI;
                    // Programs are acknowledged early; software polls STAT.busy.
                    if (op_q == OP_PROG) begin
                        ack_q <= 1'b1;
                    end
                end
                default: begin
                    to_cnt <= to_cnt + 1'b1;
                    // Only STAT reads are served while a command is in flight.
                    if (req && is_stat_rd) begin
                        ack_q <= 1'b1;
                        dat_q <= stat_word(1'b1, err_q, stat_q);
                    end
                    if (tmo) begin
                        state  <= S_IDLE;
                        err_q  <= 1'b1;
                        stat_q <= 2'b11;
                        if (op_q != OP_PROG) begin
                            ack_q <= 1'b1;
                            dat_q <= TIMEOUT_DATA;
                        end
                    end else if (done) begin
                        state  <= S_IDLE;
                        stat_q <= bus.fm_status;
                        if (bus.fm_status != 2'b00) err_q <= 1'b1;
                        if (op_q == OP_READ) dat_q <= bus.fm_rd[15:0];
                        if (op_q != OP_PROG) begin
                            ack_q <= 1'b1;
                            if (AUTO_INC != 0) addr_q <= addr_q + 17'd1;
                        end
                    end else if (state == S_WAIT_HI) begin
                        // Busy may never be seen for a zero-latency operation.
                        if (bus.fm_busy || hi_cnt == 2'd3) state <= S_WAIT_LO;
                        else                               hi_cnt <= hi_cnt + 2'd1;
                    end
                end
            endcase
        end
    end
endmodule
